// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, pixel-replication shift and clear-FSM encoding.
package vga_pkg;

    localparam logic [9:0] H_VIS   = 10'd640;
    localparam logic [9:0] H_FP    = 10'd16;
    localparam logic [9:0] H_SYNC  = 10'd96;
    localparam logic [9:0] H_BP    = 10'd48;
    localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam logic [9:0] V_VIS   = 10'd480;
    localparam logic [9:0] V_FP    = 10'd10;
    localparam logic [9:0] V_SYNC  = 10'd2;
    localparam logic [9:0] V_BP    = 10'd33;
    localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Each frame-store pixel covers a 4x4 block of VGA pixels.
    localparam int unsigned SCALE_SHIFT = 2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/vga_timing.sv
// VGA pixel-tick divider plus horizontal/vertical counters with raw (unregistered)
// sync and visible flags.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       tick,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       h_sync,
    output logic       v_sync,
    output logic       visible
);

    localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

    logic [15:0] div;

    assign tick = (div == DIV_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (tick) begin
            if (hcnt == H_TOTAL - 10'd1) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_TOTAL - 10'd1) ? '0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    assign h_sync  = (hcnt >= H_VIS + H_FP) && (hcnt < H_VIS + H_FP + H_SYNC);
    assign v_sync  = (vcnt >= V_VIS + V_FP) && (vcnt < V_VIS + V_FP + V_SYNC);
    assign visible = (hcnt < H_VIS) && (vcnt < V_VIS);

endmodule

// File: rtl/vga_framebuffer.sv
// 1-bit frame store with single-pixel writes and 4x-replicated 640x480 VGA scan-out.
// Define VGA_FB_CLEAR_EN to build the post-reset clear sweep (drives busy).
module vga_framebuffer
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned FB_W    = 160,
    parameter int unsigned FB_H    = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vgae,
    input  logic [7:0] vgax,
    input  logic [7:0] vgay,
    input  logic       vgaw,
    output logic       hsync,
    output logic       vsync,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       busy
);

    localparam int unsigned DEPTH = FB_W * FB_H;
    localparam logic [14:0] FB_W15 = 15'(FB_W);
    localparam logic [14:0] FB_H15 = 15'(FB_H);

    logic        tick;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic        h_sync;
    logic        v_sync;
    logic        visible;

    vga_timing #(
        .CLK_DIV (CLK_DIV)
    ) u_timing (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .hcnt    (hcnt),
        .vcnt    (vcnt),
        .h_sync  (h_sync),
        .v_sync  (v_sync),
        .visible (visible)
    );

    logic        mem [0:DEPTH-1];
    logic [14:0] raddr;
    logic [14:0] waddr;
    logic [14:0] clr_addr;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic        mem_data;
    logic        in_range;
    logic        rdata;
    logic        vis_d;

    assign raddr    = 15'(vcnt >> SCALE_SHIFT) * FB_W15 + 15'(hcnt >> SCALE_SHIFT);
    assign waddr    = 15'(vgay) * FB_W15 + 15'(vgax);
    assign in_range = (15'(vgax) < FB_W15) && (15'(vgay) < FB_H15);

`ifdef VGA_FB_CLEAR_EN
    localparam logic [14:0] LAST = 15'(DEPTH - 1);

    logic [0:0] state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            if (clr_addr == LAST) begin
                state <= ST_RUN;
            end else begin
                clr_addr <= clr_addr + 15'd1;
            end
        end
    end

    assign busy = (state == ST_CLEAR);
`else
    assign busy     = 1'b0;
    assign clr_addr = '0;
`endif

    // Single write port: the clear sweep owns it while busy, pixel writes otherwise.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = 1'b0;
        if (busy) begin
            mem_we   = 1'b1;
            mem_addr = clr_addr;
        end else if (vgae && in_range) begin
            mem_we   = 1'b1;
            mem_addr = waddr;
            mem_data = vgaw;
        end
    end

    // Read and write share one edge, so a same-address collision returns the old bit.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
        if (tick && visible) begin
            rdata <= mem[raddr];
        end
    end

    // Flags are captured on the same tick as the read so every output lags by one pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            vis_d <= 1'b0;
        end else if (tick) begin
            hsync <= ~h_sync;
            vsync <= ~v_sync;
            vis_d <= visible;
        end
    end

    assign red   = vis_d & rdata;
    assign green = vis_d & rdata;
    assign blue  = vis_d & rdata;

endmodule
